// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR coefficient loader
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_CTRL0,
        FETCH,
        WR_COEF,
        RD_CHECK,
        WR_CTRL1,
        DONE
    } fir_state_t;

    localparam logic [31:0] CTRL_OFFSET = 32'h0000_0000;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axil_master_xact.sv
// rtl/axil_master_xact.sv - single outstanding AXI4-Lite write or read
module axil_master_xact #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic            rd_req,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic            done,
    output logic [1:0]      resp,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic [2:0]      m_axi_awprot,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic [2:0]      m_axi_arprot,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready
);

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic aw_pend, w_pend, b_pend, ar_pend, r_pend, wr_act, rd_act;

    // A channel counts as finished if it already completed or completes this cycle.
    logic aw_fin, w_fin, b_fin, ar_fin, r_fin;
    assign aw_fin = !aw_pend || m_axi_awready;
    assign w_fin  = !w_pend  || m_axi_wready;
    assign b_fin  = !b_pend  || m_axi_bvalid;
    assign ar_fin = !ar_pend || m_axi_arready;
    assign r_fin  = !r_pend  || m_axi_rvalid;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = b_pend;
    assign m_axi_arvalid = ar_pend;
    assign m_axi_rready  = r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            b_pend  <= 1'b0;
            ar_pend <= 1'b0;
            r_pend  <= 1'b0;
            wr_act  <= 1'b0;
            rd_act  <= 1'b0;
            done    <= 1'b0;
            resp    <= 2'b00;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (!wr_act && !rd_act) begin
                if (wr_req) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                    b_pend  <= 1'b1;
                    wr_act  <= 1'b1;
                end else if (rd_req) begin
                    addr_q  <= addr;
                    ar_pend <= 1'b1;
                    r_pend  <= 1'b1;
                    rd_act  <= 1'b1;
                end
            end
            if (aw_pend && m_axi_awready) aw_pend <= 1'b0;
            if (w_pend && m_axi_wready)   w_pend  <= 1'b0;
            if (b_pend && m_axi_bvalid) begin
                b_pend <= 1'b0;
                resp   <= m_axi_bresp;
            end
            if (wr_act && aw_fin && w_fin && b_fin) begin
                wr_act <= 1'b0;
                done   <= 1'b1;
            end
            if (ar_pend && m_axi_arready) ar_pend <= 1'b0;
            if (r_pend && m_axi_rvalid) begin
                r_pend <= 1'b0;
                resp   <= m_axi_rresp;
                rdata  <= m_axi_rdata;
            end
            if (rd_act && ar_fin && r_fin) begin
                rd_act <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_cfg_sequencer.sv
// rtl/fir_cfg_sequencer.sv - loads FIR coefficients over AXI4-Lite with optional readback
module fir_cfg_sequencer
    import fir_pkg::*;
#(
    parameter int          TAPS               = 53,
    parameter logic [31:0] BASE_ADDR          = 32'hA000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          VERIFY             = 1
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    input  logic                            start,
    output logic [$clog2(TAPS+1)-1:0]       coef_addr,
    output logic                            coef_rd,
    input  logic [15:0]                     coef_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [7:0]                      err_count
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int IW = $clog2(TAPS+1);
    localparam logic [AW-1:0] CTRL_ADDR = AW'(BASE_ADDR) + AW'(CTRL_OFFSET);

    fir_state_t    state;
    logic          fetch_ph, wr_req, rd_req;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data, x_rdata;
    logic          x_done, x_fail, tap_done;
    logic [1:0]    x_resp;

    axil_master_xact #(.AW(AW), .DW(DW)) u_xact (
        .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
        .wr_req(wr_req), .rd_req(rd_req), .addr(x_addr), .wdata(x_data),
        .done(x_done), .resp(x_resp), .rdata(x_rdata),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Readback compares against x_data, which still holds the value just written.
    always_comb begin
        x_fail = 1'b0;
        if (x_done) begin
            if (state == RD_CHECK) x_fail = (x_resp != RESP_OKAY) || (x_rdata != x_data);
            else                   x_fail = (x_resp != RESP_OKAY);
        end
    end

    assign tap_done = x_done && ((state == WR_COEF && VERIFY == 0) || state == RD_CHECK);

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= 8'd0;
            coef_addr <= '0;
            coef_rd   <= 1'b0;
            fetch_ph  <= 1'b0;
            wr_req    <= 1'b0;
            rd_req    <= 1'b0;
            x_addr    <= '0;
            x_data    <= '0;
        end else begin
            wr_req  <= 1'b0;
            rd_req  <= 1'b0;
            coef_rd <= 1'b0;
            done    <= 1'b0;
            if (x_fail) begin
                error     <= 1'b1;
                err_count <= sat_inc(err_count);
            end
            case (state)
                IDLE: if (start) begin
                    state     <= WR_CTRL0;
                    busy      <= 1'b1;
                    error     <= 1'b0;
                    err_count <= 8'd0;
                    x_addr    <= CTRL_ADDR;
                    x_data    <= '0;
                    wr_req    <= 1'b1;
                end
                WR_CTRL0: if (x_done) begin
                    state     <= FETCH;
                    coef_addr <= IW'(1);
                    coef_rd   <= 1'b1;
                end
                // First FETCH cycle carries the strobe; the word arrives on the second.
                FETCH: if (!fetch_ph) begin
                    fetch_ph <= 1'b1;
                end else begin
                    fetch_ph <= 1'b0;
                    x_data   <= DW'(coef_data);
                    x_addr   <= AW'(BASE_ADDR) + (AW'(coef_addr) << 2);
                    wr_req   <= 1'b1;
                    state    <= WR_COEF;
                end
                WR_COEF: if (x_done && VERIFY != 0) begin
                    rd_req <= 1'b1;
                    state  <= RD_CHECK;
                end
                WR_CTRL1: if (x_done) begin
                    done  <= (err_count == 8'd0) && !x_fail;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: ;
            endcase
            if (tap_done) begin
                if (coef_addr == IW'(TAPS)) begin
                    state  <= WR_CTRL1;
                    x_addr <= CTRL_ADDR;
                    x_data <= DW'(1);
                    wr_req <= 1'b1;
                end else begin
                    coef_addr <= coef_addr + 1'b1;
                    coef_rd   <= 1'b1;
                    state     <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb/tb_fir_cfg_sequencer.sv - directed bench for fir_cfg_sequencer with a behavioural AXI-Lite slave
module tb_fir_cfg_sequencer;

    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  coef_addr;
    logic        coef_rd;
    logic [15:0] coef_data = 16'h0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        busy, done, error;
    logic [7:0]  err_count;

    int aw_dly = 0, w_dly = 0, bad_b_idx = -1, corrupt_idx = -1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fir_cfg_sequencer dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rstn), .start(start),
        .coef_addr(coef_addr), .coef_rd(coef_rd), .coef_data(coef_data),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .done(done), .error(error), .err_count(err_count)
    );

    always @(posedge clk) if (coef_rd) coef_data <= 16'h0100 + 16'(coef_addr);

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    logic [31:0] mem [0:63];
    logic [31:0] wr_addr_log [0:127];
    logic [31:0] wr_data_log [0:127];
    logic [31:0] lat_addr, lat_data;
    logic        aw_got, w_got;
    int          aw_cnt, w_cnt, wr_cnt, rd_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
        end else begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            if (clr) begin wr_cnt <= 0; rd_cnt <= 0; end
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_dly) awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && awready) begin aw_got <= 1'b1; lat_addr <= awaddr; aw_cnt <= 0; end
            if (wvalid && !wready && !w_got) begin
                if (w_cnt >= w_dly) wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (wvalid && wready) begin w_got <= 1'b1; lat_data <= wdata; w_cnt <= 0; end
            if (aw_got && w_got && !bvalid) begin
                mem[widx(lat_addr)]  <= lat_data;
                wr_addr_log[wr_cnt] <= lat_addr;
                wr_data_log[wr_cnt] <= lat_data;
                wr_cnt <= wr_cnt + 1;
                bvalid <= 1'b1;
                bresp  <= (widx(lat_addr) == bad_b_idx) ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && !arready && !rvalid) arready <= 1'b1;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= mem[widx(araddr)] ^ ((widx(araddr) == corrupt_idx) ? 32'h1 : 32'h0);
                rd_cnt <= rd_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // Protocol observer, sampled mid-cycle.
    int   done_cnt, b_cnt, viol, attr_bad, overlap;
    logic saw_aw_first;
    logic p_rstn, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge clk) begin
        if (clr) begin
            done_cnt <= 0; b_cnt <= 0; viol <= 0; attr_bad <= 0; overlap <= 0; saw_aw_first <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (bvalid && bready) b_cnt <= b_cnt + 1;
            if (!awvalid && wvalid) saw_aw_first <= 1'b1;
            if ((awvalid && awprot != 3'd0) || (wvalid && wstrb != 4'hF) || (arvalid && arprot != 3'd0))
                attr_bad <= attr_bad + 1;
            if ((arvalid || rready) && (awvalid || wvalid || bready)) overlap <= overlap + 1;
            if (rstn && p_rstn &&
                ((p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) ||
                 (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) ||
                 (p_arv && !p_arr && (!arvalid || araddr != p_araddr))))
                viol <= viol + 1;
        end
        p_rstn <= rstn; p_awv <= awvalid; p_awr <= awready; p_wv <= wvalid; p_wr <= wready;
        p_arv <= arvalid; p_arr <= arready; p_awaddr <= awaddr; p_wdata <= wdata; p_araddr <= araddr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge clk); #1 clr = 1'b1;
        @(negedge clk); #1 clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
        check({tag, "_coef_addr"}, {26'd0, coef_addr}, 32'd0);
        check({tag, "_strobes"}, {25'd0, coef_rd, awvalid, wvalid, bready, arvalid, rready, 1'b0}, 32'd0);
    endtask

    task automatic check_full_run(input string tag, input int exp_rd);
        check({tag, "_wr_cnt"}, wr_cnt, 32'd55);
        check({tag, "_rd_cnt"}, rd_cnt, exp_rd);
        check({tag, "_ctrl0_addr"}, wr_addr_log[0], BASE);
        check({tag, "_ctrl0_data"}, wr_data_log[0], 32'd0);
        check({tag, "_ctrl1_addr"}, wr_addr_log[54], BASE);
        check({tag, "_ctrl1_data"}, wr_data_log[54], 32'd1);
        check({tag, "_b_cnt"}, b_cnt, 32'd55);
        check({tag, "_viol"}, viol, 32'd0);
        check({tag, "_attr"}, attr_bad, 32'd0);
        check({tag, "_overlap"}, overlap, 32'd0);
    endtask

    initial begin
        int n;
        int snap;
        repeat (3) @(negedge clk);
        check_outputs_reset("rst_in");
        #2 rstn = 1'b1;
        clear_logs();
        check_outputs_reset("rst_out");

        // Zero-wait slave, full verify run.
        pulse_start();
        check("a_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        check_full_run("a", 53);
        for (int k = 1; k <= 53; k++) begin
            check("a_coef_addr", wr_addr_log[k], BASE + 32'(4 * k));
            check("a_coef_data", wr_data_log[k], 32'h0100 + 32'(k));
        end
        check("a_done_cnt", done_cnt, 32'd1);
        check("a_error", {31'd0, error}, 32'd0);
        check("a_errcnt", {24'd0, err_count}, 32'd0);

        // Write data accepted three cycles after the address.
        w_dly = 3;
        clear_logs();
        pulse_start();
        wait_idle();
        check_full_run("b", 53);
        check("b_aw_first", {31'd0, saw_aw_first}, 32'd1);
        check("b_mem7", mem[7], 32'h0107);
        check("b_mem53", mem[53], 32'h0135);
        check("b_done_cnt", done_cnt, 32'd1);
        check("b_error", {31'd0, error}, 32'd0);
        w_dly = 0;

        // SLVERR on tap 7.
        bad_b_idx = 7;
        clear_logs();
        pulse_start();
        wait_idle();
        check_full_run("c", 53);
        check("c_error", {31'd0, error}, 32'd1);
        check("c_errcnt", {24'd0, err_count}, 32'd1);
        check("c_done_cnt", done_cnt, 32'd0);
        bad_b_idx = -1;

        // Corrupted readback on tap 20; the new start also clears the old error.
        corrupt_idx = 20;
        clear_logs();
        pulse_start();
        check("d_err_cleared", {31'd0, error}, 32'd0);
        check("d_cnt_cleared", {24'd0, err_count}, 32'd0);
        wait_idle();
        check_full_run("d", 53);
        check("d_error", {31'd0, error}, 32'd1);
        check("d_errcnt", {24'd0, err_count}, 32'd1);
        check("d_done_cnt", done_cnt, 32'd0);
        corrupt_idx = -1;

        // Reset during the tap-30 write.
        clear_logs();
        pulse_start();
        n = 0;
        while (!(awvalid && awaddr == BASE + 32'h78) && n < 5000) begin @(negedge clk); n++; end
        check("e_reach_tap30", {31'd0, awvalid && awaddr == BASE + 32'h78}, 32'd1);
        #2 rstn = 1'b0;
        #1 check_outputs_reset("e_async");
        repeat (3) @(negedge clk);
        check_outputs_reset("e_held");
        #2 rstn = 1'b1;
        snap = wr_cnt;
        repeat (6) @(negedge clk);
        check("e_no_resume_busy", {31'd0, busy}, 32'd0);
        check("e_no_resume_wr", wr_cnt, snap);
        clear_logs();
        pulse_start();
        wait_idle();
        check_full_run("e", 53);
        check("e_done_cnt", done_cnt, 32'd1);

        // Extra starts while busy are ignored.
        clear_logs();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check_full_run("f", 53);
        check("f_done_cnt", done_cnt, 32'd1);
        check("f_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
